pipelined_control_unit: RTL and testbench

- Successor to the single-cycle decoder. Decodes opcode/funct3 in the ID stage and carries the control word through ID/EX, EX/MEM and MEM/WB control registers.
- Handles stall, flush and bubble insertion, and flags illegal opcodes.
- Adds a BRANCH_SET mode (all RV32I branch conditions), optional AUIPC, and an ALU source-A select.
- Sits in the control path beside the datapath pipeline registers; the hazard unit drives its stall/flush inputs.

---
 rtl/pipelined_control_unit_pkg.sv | 54 +++++
 rtl/pipelined_control_unit_if.sv | 33 +++
 rtl/pipelined_control_unit_control_decoder.sv | 75 +++++++
 rtl/pipelined_control_unit.sv | 52 +++++
 tb/tb_pipelined_control_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: opcodes, select codes, branch funct3 values and pipeline control-word types
package pipelined_control_unit_pkg;
  localparam logic [6:0] OP_R_TYPE       = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I_TYPE_ALU   = 7'b0010011;
  localparam logic [6:0] OP_I_TYPE_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S_TYPE       = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE       = 7'b1100011;
  localparam logic [6:0] OP_J_TYPE_JAL   = 7'b1101111;
  localparam logic [6:0] OP_U_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_TYPE_AUIPC = 7'b0010111;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       reg_write;
    logic       jmp;
    logic       branch;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       alu_src_a;
    logic [2:0] branch_cond;
  } ctrl_t;
  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       reg_write;
  } mem_ctrl_t;
  typedef struct packed {
    logic [1:0] result_src;
    logic       reg_write;
  } wb_ctrl_t;
  localparam ctrl_t BUBBLE = '0;
  function automatic logic branch_ok(logic [2:0] f3, bit branch_set);
    return (f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU}) && (branch_set || f3 == F3_BEQ);
  endfunction
endpackage

// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: ID opcode/funct3 and hazard stall/flush in (master drives), per-stage control out (slave drives)
interface pipelined_control_unit_if #(parameter int ALU_OP_W = 2, parameter int IMM_SRC_W = 3);
  logic [6:0]           i_opcode;
  logic [2:0]           i_funct3;
  logic                 i_stall_e;
  logic                 i_flush_e;
  logic [IMM_SRC_W-1:0] o_imm_src_d;
  logic                 o_illegal_d;
  logic [ALU_OP_W-1:0]  o_alu_op_e;
  logic                 o_alu_src_e;
  logic                 o_alu_src_a_e;
  logic                 o_jmp_e;
  logic                 o_branch_e;
  logic [2:0]           o_branch_cond_e;
  logic [1:0]           o_result_src_e;
  logic                 o_reg_write_m;
  logic                 o_mem_write_m;
  logic [1:0]           o_result_src_m;
  logic                 o_reg_write_w;
  logic [1:0]           o_result_src_w;
  modport master (
    output i_opcode, i_funct3, i_stall_e, i_flush_e,
    input  o_imm_src_d, o_illegal_d, o_alu_op_e, o_alu_src_e, o_alu_src_a_e, o_jmp_e, o_branch_e,
           o_branch_cond_e, o_result_src_e, o_reg_write_m, o_mem_write_m, o_result_src_m,
           o_reg_write_w, o_result_src_w
  );
  modport slave (
    input  i_opcode, i_funct3, i_stall_e, i_flush_e,
    output o_imm_src_d, o_illegal_d, o_alu_op_e, o_alu_src_e, o_alu_src_a_e, o_jmp_e, o_branch_e,
           o_branch_cond_e, o_result_src_e, o_reg_write_m, o_mem_write_m, o_result_src_m,
           o_reg_write_w, o_result_src_w
  );
endinterface

// File: rtl/pipelined_control_unit_control_decoder.sv
// control_decoder: combinational opcode/funct3 -> control word, immediate select and illegal flag (illegal decodes become a bubble)
module control_decoder import pipelined_control_unit_pkg::*; #(
  parameter bit ENABLE_AUIPC = 1'b1,
  parameter bit BRANCH_SET   = 1'b1
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output ctrl_t      o_ctrl,
  output logic [2:0] o_imm_src,
  output logic       o_illegal
);
  always_comb begin
    o_ctrl    = BUBBLE;
    o_imm_src = IMM_I;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R_TYPE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_I_TYPE_LOAD: begin
        o_ctrl.result_src = RES_MEM;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_I_TYPE_ALU: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_I_TYPE_JALR: begin
        o_ctrl.result_src = RES_PC4;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jmp        = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_S_TYPE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_imm_src        = IMM_S;
      end
      OP_B_TYPE: begin
        o_ctrl.branch      = 1'b1;
        o_ctrl.alu_op      = ALU_BRANCH;
        o_ctrl.branch_cond = i_funct3;
        o_imm_src          = IMM_B;
        o_illegal          = !branch_ok(i_funct3, BRANCH_SET);
      end
      OP_J_TYPE_JAL: begin
        o_ctrl.result_src = RES_PC4;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jmp        = 1'b1;
        o_imm_src         = IMM_J;
      end
      OP_U_TYPE_LUI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_PASS_B;
        o_ctrl.alu_src   = 1'b1;
        o_imm_src        = IMM_U;
      end
      OP_U_TYPE_AUIPC: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_src_a = 1'b1;
        o_imm_src        = IMM_U;
        o_illegal        = !ENABLE_AUIPC;
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_ctrl    = BUBBLE;
      o_imm_src = IMM_I;
    end
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode plus ID/EX, EX/MEM, MEM/WB control registers with stall/flush bubbles; clk i_clk, sync active-low i_rst_n, rest on bus
module pipelined_control_unit import pipelined_control_unit_pkg::*; #(
  parameter int ALU_OP_W     = 2,
  parameter int IMM_SRC_W    = 3,
  parameter bit ENABLE_AUIPC = 1'b1,
  parameter bit BRANCH_SET   = 1'b1
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  pipelined_control_unit_if.slave  bus
);
  ctrl_t      dec_ctrl, ex_q, ex_d;
  mem_ctrl_t  mem_q, mem_d;
  wb_ctrl_t   wb_q, wb_d;
  logic [2:0] imm_src;
  control_decoder #(.ENABLE_AUIPC(ENABLE_AUIPC), .BRANCH_SET(BRANCH_SET)) u_dec (
    .i_opcode  (bus.i_opcode),
    .i_funct3  (bus.i_funct3),
    .o_ctrl    (dec_ctrl),
    .o_imm_src (imm_src),
    .o_illegal (bus.o_illegal_d)
  );
  always_comb begin
    ex_d  = bus.i_flush_e ? BUBBLE : bus.i_stall_e ? ex_q : dec_ctrl;
    mem_d = (bus.i_stall_e && !bus.i_flush_e) ? '0 : {ex_q.result_src, ex_q.mem_write, ex_q.reg_write};
    wb_d  = {mem_q.result_src, mem_q.reg_write};
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end
  assign bus.o_imm_src_d     = IMM_SRC_W'(imm_src);
  assign bus.o_alu_op_e      = ALU_OP_W'(ex_q.alu_op);
  assign bus.o_alu_src_e     = ex_q.alu_src;
  assign bus.o_alu_src_a_e   = ex_q.alu_src_a;
  assign bus.o_jmp_e         = ex_q.jmp;
  assign bus.o_branch_e      = ex_q.branch;
  assign bus.o_branch_cond_e = ex_q.branch_cond;
  assign bus.o_result_src_e  = ex_q.result_src;
  assign bus.o_reg_write_m   = mem_q.reg_write;
  assign bus.o_mem_write_m   = mem_q.mem_write;
  assign bus.o_result_src_m  = mem_q.result_src;
  assign bus.o_reg_write_w   = wb_q.reg_write;
  assign bus.o_result_src_w  = wb_q.result_src;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: scoreboard bench for default and restricted (no AUIPC, beq-only) control units
module tb_pipelined_control_unit;
  typedef struct packed {
    logic [1:0] rs;
    logic mw, rw, j, b;
    logic [1:0] aop;
    logic as, asa;
    logic [2:0] bc;
  } cw_t;
  typedef struct packed {
    logic ill;
    logic [2:0] imm;
    cw_t cw;
  } dec_t;
  typedef struct packed {
    cw_t ex;
    logic [1:0] mrs;
    logic mmw, mrw;
    logic [1:0] wrs;
    logic wrw;
  } st_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  st_t m [2];
  logic [17:0] q [$];
  logic [6:0] ops [11];
  always #5 clk = ~clk;
  pipelined_control_unit_if b0 ();
  pipelined_control_unit_if b1 ();
  pipelined_control_unit u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  pipelined_control_unit #(.ENABLE_AUIPC(1'b0), .BRANCH_SET(1'b0)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
  endtask
  function automatic dec_t ref_dec(logic [6:0] op, logic [2:0] f3, bit bset, bit aen);
    dec_t d = '0;
    case (op)
      7'b0110011: d.cw = {2'b00, 4'b0100, 2'b10, 2'b00, 3'b000};
      7'b0000011: d.cw = {2'b01, 4'b0100, 2'b00, 2'b10, 3'b000};
      7'b0010011: d.cw = {2'b00, 4'b0100, 2'b10, 2'b10, 3'b000};
      7'b1100111: d.cw = {2'b10, 4'b0110, 2'b00, 2'b10, 3'b000};
      7'b0100011: begin d.cw = {2'b00, 4'b1000, 2'b00, 2'b10, 3'b000}; d.imm = 3'b001; end
      7'b1100011: begin
        d.cw = {2'b00, 4'b0001, 2'b01, 2'b00, f3};
        d.imm = 3'b010;
        d.ill = (f3 == 3'b010) || (f3 == 3'b011) || (!bset && f3 != 3'b000);
      end
      7'b1101111: begin d.cw = {2'b10, 4'b0110, 2'b00, 2'b00, 3'b000}; d.imm = 3'b011; end
      7'b0110111: begin d.cw = {2'b00, 4'b0100, 2'b11, 2'b10, 3'b000}; d.imm = 3'b100; end
      7'b0010111: begin d.cw = {2'b00, 4'b0100, 2'b00, 2'b11, 3'b000}; d.imm = 3'b100; d.ill = !aen; end
      default: d.ill = 1'b1;
    endcase
    if (d.ill) begin
      d = '0;
      d.ill = 1'b1;
    end
    return d;
  endfunction
  function automatic st_t nxt(st_t s, dec_t d, logic r, logic st, logic fl);
    st_t n;
    if (!r) return '0;
    n.wrs = s.mrs;
    n.wrw = s.mrw;
    {n.mrs, n.mmw, n.mrw} = (st && !fl) ? 4'b0 : {s.ex.rs, s.ex.mw, s.ex.rw};
    n.ex = fl ? cw_t'(0) : st ? s.ex : d.cw;
    return n;
  endfunction
  function automatic logic [17:0] vis(st_t s);
    return {s.ex.rs, s.ex.j, s.ex.b, s.ex.aop, s.ex.as, s.ex.asa, s.ex.bc, s.mrs, s.mmw, s.mrw, s.wrs, s.wrw};
  endfunction
  function automatic logic [17:0] observe(int k);
    return k == 0 ?
      {b0.o_result_src_e, b0.o_jmp_e, b0.o_branch_e, b0.o_alu_op_e, b0.o_alu_src_e, b0.o_alu_src_a_e, b0.o_branch_cond_e,
       b0.o_result_src_m, b0.o_mem_write_m, b0.o_reg_write_m, b0.o_result_src_w, b0.o_reg_write_w} :
      {b1.o_result_src_e, b1.o_jmp_e, b1.o_branch_e, b1.o_alu_op_e, b1.o_alu_src_e, b1.o_alu_src_a_e, b1.o_branch_cond_e,
       b1.o_result_src_m, b1.o_mem_write_m, b1.o_reg_write_m, b1.o_result_src_w, b1.o_reg_write_w};
  endfunction
  task automatic drive(logic r, logic [6:0] op, logic [2:0] f3, logic st, logic fl);
    dec_t d0, d1;
    @(negedge clk);
    rst_n = r;
    b0.i_opcode = op; b0.i_funct3 = f3; b0.i_stall_e = st; b0.i_flush_e = fl;
    b1.i_opcode = op; b1.i_funct3 = f3; b1.i_stall_e = st; b1.i_flush_e = fl;
    #1;
    d0 = ref_dec(op, f3, 1'b1, 1'b1);
    d1 = ref_dec(op, f3, 1'b0, 1'b0);
    check("illegal_d0", b0.o_illegal_d, d0.ill);
    check("imm_src_d0", b0.o_imm_src_d, d0.imm);
    check("illegal_d1", b1.o_illegal_d, d1.ill);
    check("imm_src_d1", b1.o_imm_src_d, d1.imm);
    m[0] = nxt(m[0], d0, r, st, fl);
    m[1] = nxt(m[1], d1, r, st, fl);
    q.push_back(vis(m[0]));
    q.push_back(vis(m[1]));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check(k == 0 ? "pipe0" : "pipe1", observe(k), q.pop_front());
  endtask
  task automatic cyc(logic r, logic [6:0] op, logic [2:0] f3, logic st, logic fl);
    drive(r, op, f3, st, fl);
    step();
  endtask
  initial begin
    m[0] = '0;
    m[1] = '0;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};
    cyc(1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0);
    check("rst_reg_write_w", b0.o_reg_write_w, 1'b0);
    check("rst_alu_op_e", b0.o_alu_op_e, 2'b00);
    cyc(1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0);
    check("rw_w_edge2", b0.o_reg_write_w, 1'b0);
    cyc(1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0);
    check("rw_w_edge3", b0.o_reg_write_w, 1'b1);
    cyc(1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0);
    check("lw_rs_e", b0.o_result_src_e, 2'b01);
    cyc(1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0);
    check("lw_rs_m", b0.o_result_src_m, 2'b01);
    check("r_rs_e", b0.o_result_src_e, 2'b00);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    check("lw_rs_w", b0.o_result_src_w, 2'b01);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    check("r_rs_w", b0.o_result_src_w, 2'b00);
    cyc(1'b1, 7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b1, 1'b0);
    check("stall_mw_m", b0.o_mem_write_m, 1'b0);
    check("stall_hold_e", b0.o_alu_src_e, 1'b1);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    check("sw_mw_m", b0.o_mem_write_m, 1'b1);
    cyc(1'b1, 7'b0110011, 3'b000, 1'b1, 1'b1);
    check("flush_alu_op_e", b0.o_alu_op_e, 2'b00);
    drive(1'b1, 7'b1100011, 3'b001, 1'b0, 1'b0);
    check("bne_ill0", b0.o_illegal_d, 1'b0);
    check("bne_ill1", b1.o_illegal_d, 1'b1);
    step();
    check("bne_branch_e0", b0.o_branch_e, 1'b1);
    check("bne_cond_e0", b0.o_branch_cond_e, 3'b001);
    check("bne_alu_op_e0", b0.o_alu_op_e, 2'b01);
    check("bne_branch_e1", b1.o_branch_e, 1'b0);
    drive(1'b1, 7'b0010111, 3'b000, 1'b0, 1'b0);
    check("auipc_imm0", b0.o_imm_src_d, 3'b100);
    check("auipc_ill1", b1.o_illegal_d, 1'b1);
    step();
    check("auipc_src_a_e0", b0.o_alu_src_a_e, 1'b1);
    cyc(1'b1, 7'b0110111, 3'b000, 1'b0, 1'b0);
    check("lui_alu_op_e0", b0.o_alu_op_e, 2'b11);
    check("lui_src_a_e0", b0.o_alu_src_a_e, 1'b0);
    drive(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    check("ill_flag0", b0.o_illegal_d, 1'b1);
    check("ill_imm0", b0.o_imm_src_d, 3'b000);
    step();
    check("ill_alu_src_e0", b0.o_alu_src_e, 1'b0);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    check("ill_reg_write_m0", b0.o_reg_write_m, 1'b0);
    cyc(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0);
    check("ill_reg_write_w0", b0.o_reg_write_w, 1'b0);
    for (int i = 0; i < 120; i++)
      cyc($urandom_range(0, 19) != 0, ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
